// File: rtl/b_dmem_if.sv
// Data-memory bus between the CPU MEM/WB stage and b_dmem.
// The bus also carries the TX byte stream that leaves the memory-mapped FIFO.
interface b_dmem_if;
  logic [31:0] i_b_dmem_addr;
  logic [31:0] i_b_dmem_wr_data;
  logic        i_b_dmem_word;
  logic        i_b_dmem_mem_wr;
  logic [31:0] o_b_dmem_rd_data;
  logic [7:0]  o_b_dmem_tx_data;
  logic        o_b_dmem_tx_valid;
  logic        i_b_dmem_tx_ready;

  // Memory side
  modport slave (
    input  i_b_dmem_addr, i_b_dmem_wr_data, i_b_dmem_word, i_b_dmem_mem_wr,
    input  i_b_dmem_tx_ready,
    output o_b_dmem_rd_data, o_b_dmem_tx_data, o_b_dmem_tx_valid
  );

  // CPU / downstream side
  modport master (
    output i_b_dmem_addr, i_b_dmem_wr_data, i_b_dmem_word, i_b_dmem_mem_wr,
    output i_b_dmem_tx_ready,
    input  o_b_dmem_rd_data, o_b_dmem_tx_data, o_b_dmem_tx_valid
  );
endinterface

// File: rtl/b_dmem.sv
// Data memory with memory-mapped TX FIFO, status register and free-running
// cycle counter. Loads are combinational, so the CPU samples them on the same
// edge that commits stores.
module b_dmem #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
  parameter int unsigned FIFO_DEPTH  = 4       // power of 2, at least 2
) (
  input logic      i_sys_clock,
  input logic      i_sys_reset,
  b_dmem_if.slave  bus
);

  localparam int unsigned AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned PW        = $clog2(FIFO_DEPTH);
  localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH_WORDS);
  localparam logic [31:0] TXD_ADDR  = 32'hFFFF_0000;
  localparam logic [31:0] STAT_ADDR = 32'hFFFF_0004;
  localparam logic [31:0] CNT_ADDR  = 32'hFFFF_0008;
  localparam logic [PW:0] FULL_CNT  = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    REG_RAM,
    REG_TXD,
    REG_STAT,
    REG_CNT,
    REG_ILL
  } region_e;

  // Bus aliases
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic        word;
  logic        mem_wr;
  logic        tx_ready;

  assign addr     = bus.i_b_dmem_addr;
  assign wr_data  = bus.i_b_dmem_wr_data;
  assign word     = bus.i_b_dmem_word;
  assign mem_wr   = bus.i_b_dmem_mem_wr;
  assign tx_ready = bus.i_b_dmem_tx_ready;

  // State
  logic [31:0]   ram_q [DEPTH_WORDS];
  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          err_q, err_d;
  logic [31:0]   cnt_q, cnt_d;

  // Decode
  logic [31:0]   offset;
  logic [AW-1:0] word_idx;
  logic [1:0]    lane;
  region_e       region;
  logic          access_err;

  // Subtracting the base lets one unsigned compare reject addresses on both
  // sides of the RAM window.
  assign offset   = addr - BASE_ADDR;
  assign word_idx = offset[AW+1:2];
  assign lane     = addr[1:0];

  // Classify the current address into a region
  // NOTE: every variable written in an always_comb gets a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    region = REG_ILL;
    if (offset < RAM_BYTES)      region = REG_RAM;
    else if (addr == TXD_ADDR)   region = REG_TXD;
    else if (addr == STAT_ADDR)  region = REG_STAT;
    else if (addr == CNT_ADDR)   region = REG_CNT;
  end

  // Flag misaligned word accesses, byte accesses to registers and unmapped addresses
  always_comb begin
    access_err = 1'b0;
    case (region)
      REG_RAM:                    access_err = word && (lane != 2'b00);
      REG_TXD, REG_STAT, REG_CNT: access_err = !word;
      default:                    access_err = 1'b1;
    endcase
  end

  // Strobes; nothing commits while reset is asserted
  logic store_ok, ram_we, push_req, push_ok, push_drop, stat_wr, pop;
  logic tx_valid;

  assign tx_valid  = (count_q != '0);
  assign store_ok  = mem_wr && !access_err && !i_sys_reset;
  assign ram_we    = store_ok && (region == REG_RAM);
  assign stat_wr   = store_ok && (region == REG_STAT);
  assign push_req  = store_ok && (region == REG_TXD);
  assign pop       = tx_valid && tx_ready && !i_sys_reset;
  // A full FIFO still takes the byte when the head leaves on the same edge.
  assign push_ok   = push_req && ((count_q != FULL_CNT) || pop);
  assign push_drop = push_req && !push_ok;

  // Load path
  logic [31:0] ram_word;
  logic [7:0]  ram_byte;
  logic [31:0] count_ext;
  logic [2:0]  count_field;
  logic [31:0] stat_word;
  logic [31:0] rd_data;

  assign ram_word    = ram_q[word_idx];
  assign ram_byte    = 8'(ram_word >> {lane, 3'b000});
  assign count_ext   = 32'(count_q);
  assign count_field = (count_ext > 32'd7) ? 3'd7 : count_ext[2:0];
  assign stat_word   = {22'b0, err_q, ovf_q, 3'b0, !tx_valid,
                        (count_q == FULL_CNT), count_field};

  // Select load data; errors and TXD reads return zero
  always_comb begin
    rd_data = '0;
    if (!access_err) begin
      case (region)
        REG_RAM:  rd_data = word ? ram_word : {{24{ram_byte[7]}}, ram_byte};
        REG_STAT: rd_data = stat_word;
        REG_CNT:  rd_data = cnt_q;
        default:  rd_data = '0;
      endcase
    end
  end

  assign bus.o_b_dmem_rd_data  = rd_data;
  assign bus.o_b_dmem_tx_valid = tx_valid;
  assign bus.o_b_dmem_tx_data  = tx_valid ? fifo_q[rd_ptr_q] : 8'h00;

  // Commit RAM stores, word or single byte lane
  // NOTE: storage arrays are deliberately left out of reset; contents survive
  // reset and the array maps onto plain RAM without a clear path.
  always_ff @(posedge i_sys_clock) begin
    if (ram_we) begin
      if (word) ram_q[word_idx] <= wr_data;
      else      ram_q[word_idx][{lane, 3'b000} +: 8] <= wr_data[7:0];
    end
  end

  // Write accepted bytes into the FIFO storage
  always_ff @(posedge i_sys_clock) begin
    if (push_ok) fifo_q[wr_ptr_q] <= wr_data[7:0];
  end

  // Next-state for pointers, count, sticky flags and cycle counter
  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop     ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // Set dominates clear when both happen on the same edge.
    ovf_d = (ovf_q && !(stat_wr && wr_data[8])) || push_drop;
    err_d = (err_q && !(stat_wr && wr_data[9])) || access_err;
    cnt_d = cnt_q + 32'd1;
  end

  // Control registers with synchronous reset
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_sys_clock) begin
    if (i_sys_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule
